// File: rtl/aer_pkg.sv
// Shared types and constants for the AER core event distributor.
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        ACK     = 2'd2
    } aer_state_e;

    typedef enum logic [1:0] {
        UCAST = 2'd0,
        BCAST = 2'd1,
        DROP  = 2'd2
    } aer_cls_e;

    localparam logic [1:0] BCAST_PREFIX = 2'b01;

    // Floors at 1 so a single-core build still has a legal core_id field.
    function automatic int core_id_w(input int core_num);
        return (core_num > 1) ? $clog2(core_num) : 1;
    endfunction

endpackage

// File: rtl/aer_sat_counter.sv
// Saturating event counter: holds at all ones instead of wrapping.
// Latency: count visible the cycle after inc.
// Backpressure: none; inc is sampled every cycle.
module aer_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aer_core_event_distributor.sv
// Decodes a merged {payload, core_id} AER stream and delivers it to one core or all cores.
// Latency: core_req one cycle after evt_req; evt_ack the cycle after the last core_ack.
// Backpressure: evt_ack is withheld until every addressed core has acked; one event in flight.
module aer_core_event_distributor
    import aer_pkg::*;
#(
    parameter int CORE_NUM      = 16,
    parameter int AER_OUT_WIDTH = 8,
    parameter int CNT_W         = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          evt_req,
    input  logic [AER_OUT_WIDTH+core_id_w(CORE_NUM)-1:0]  evt_addr,
    output logic                                          evt_ack,
    output logic [CORE_NUM-1:0]                           core_req,
    output logic [CORE_NUM*AER_OUT_WIDTH-1:0]             core_addr,
    input  logic [CORE_NUM-1:0]                           core_ack,
    output logic [CNT_W-1:0]                              ucast_cnt,
    output logic [CNT_W-1:0]                              bcast_cnt,
    output logic [CNT_W-1:0]                              drop_cnt
);

    localparam int CORE_ID_W = core_id_w(CORE_NUM);
    localparam int EVENT_W   = AER_OUT_WIDTH + CORE_ID_W;
    localparam logic [CORE_ID_W:0]   CORE_NUM_V  = (CORE_ID_W+1)'(CORE_NUM);
    localparam logic [CORE_NUM-1:0]  ONE_HOT_LSB = CORE_NUM'(1);

    aer_state_e                 state_q, state_d;
    aer_cls_e                   cls_q, cls_d, cls_in;
    logic [AER_OUT_WIDTH-1:0]   payload_q, payload_d, payload_in;
    logic [CORE_ID_W-1:0]       id_in;
    logic [CORE_NUM-1:0]        pend_q, pend_d, pend_clr;
    logic                       evt_ack_q;
    logic                       inc_ucast, inc_bcast, inc_drop;

    assign payload_in = evt_addr[EVENT_W-1 -: AER_OUT_WIDTH];
    assign id_in      = evt_addr[CORE_ID_W-1:0];
    // Acks on bits that are not pending fall out of the AND and are ignored.
    assign pend_clr   = pend_q & ~core_ack;

    always_comb begin
        if (payload_in[AER_OUT_WIDTH-1 -: 2] == BCAST_PREFIX) begin
            cls_in = BCAST;
        end else if ({1'b0, id_in} >= CORE_NUM_V) begin
            cls_in = DROP;
        end else begin
            cls_in = UCAST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (evt_req) state_d = (cls_in == DROP) ? ACK : DELIVER;
            DELIVER: if (pend_clr == '0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        payload_d = payload_q;
        cls_d     = cls_q;
        pend_d    = pend_q;
        inc_ucast = 1'b0;
        inc_bcast = 1'b0;
        inc_drop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt_req) begin
                    payload_d = payload_in;
                    cls_d     = cls_in;
                    case (cls_in)
                        BCAST:   pend_d = '1;
                        UCAST:   pend_d = ONE_HOT_LSB << id_in;
                        default: pend_d = '0;
                    endcase
                end
            end
            DELIVER: begin
                pend_d = pend_clr;
                if (pend_clr == '0) begin
                    inc_ucast = (cls_q == UCAST);
                    inc_bcast = (cls_q == BCAST);
                end
            end
            ACK: inc_drop = (cls_q == DROP);
            default: pend_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            cls_q     <= UCAST;
            pend_q    <= '0;
            evt_ack_q <= 1'b0;
        end else begin
            payload_q <= payload_d;
            cls_q     <= cls_d;
            pend_q    <= pend_d;
            evt_ack_q <= (state_d == ACK);
        end
    end

    // Pending mask is zero outside DELIVER, so it drives core_req directly.
    assign core_req  = pend_q;
    assign core_addr = {CORE_NUM{payload_q}};
    assign evt_ack   = evt_ack_q;

    aer_sat_counter #(.W(CNT_W)) u_ucast_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_ucast),
        .cnt   (ucast_cnt)
    );

    aer_sat_counter #(.W(CNT_W)) u_bcast_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_bcast),
        .cnt   (bcast_cnt)
    );

    aer_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_drop),
        .cnt   (drop_cnt)
    );

endmodule

// File: tb/tb_aer_core_event_distributor.sv
// Directed bench: a 16-core instance with 4-bit counters and a 12-core instance for out-of-range ids.
module tb_aer_core_event_distributor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          evt_req;
    logic [11:0]   evt_addr;
    logic          evt_ack;
    logic [15:0]   core_req;
    logic [127:0]  core_addr;
    logic [15:0]   core_ack;
    logic [3:0]    ucast_cnt, bcast_cnt, drop_cnt;

    logic          r_evt_req;
    logic [11:0]   r_evt_addr;
    logic          r_evt_ack;
    logic [11:0]   r_core_req;
    logic [95:0]   r_core_addr;
    logic [11:0]   r_core_ack;
    logic [15:0]   r_ucast_cnt, r_bcast_cnt, r_drop_cnt;

    aer_core_event_distributor #(.CORE_NUM(16), .AER_OUT_WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_req   (evt_req),
        .evt_addr  (evt_addr),
        .evt_ack   (evt_ack),
        .core_req  (core_req),
        .core_addr (core_addr),
        .core_ack  (core_ack),
        .ucast_cnt (ucast_cnt),
        .bcast_cnt (bcast_cnt),
        .drop_cnt  (drop_cnt)
    );

    aer_core_event_distributor #(.CORE_NUM(12), .AER_OUT_WIDTH(8), .CNT_W(16)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_req   (r_evt_req),
        .evt_addr  (r_evt_addr),
        .evt_ack   (r_evt_ack),
        .core_req  (r_core_req),
        .core_addr (r_core_addr),
        .core_ack  (r_core_ack),
        .ucast_cnt (r_ucast_cnt),
        .bcast_cnt (r_bcast_cnt),
        .drop_cnt  (r_drop_cnt)
    );

    int tests = 0;
    int fails = 0;
    int ack_pulses = 0;

    always @(posedge clk) begin
        if (evt_ack === 1'b1) ack_pulses <= ack_pulses + 1;
    end

    typedef struct {
        logic [11:0] addr;
        logic [15:0] exp_req;
        logic [7:0]  exp_pl;
        logic        is_bc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_u;
        int exp_b;
        int pulses_before;
        logic [15:0] m;

        rst_n = 1'b0;
        evt_req = 1'b0; evt_addr = '0; core_ack = '0;
        r_evt_req = 1'b0; r_evt_addr = '0; r_core_ack = '0;

        vecs[0] = '{{8'h35, 4'd7},  16'h0080, 8'h35, 1'b0};
        vecs[1] = '{{8'hA1, 4'd0},  16'h0001, 8'hA1, 1'b0};
        vecs[2] = '{{8'h40, 4'd15}, 16'hFFFF, 8'h40, 1'b1};
        vecs[3] = '{{8'hBF, 4'd15}, 16'h8000, 8'hBF, 1'b0};
        vecs[4] = '{{8'h3C, 4'd2},  16'h0004, 8'h3C, 1'b0};
        vecs[5] = '{{8'h7E, 4'd9},  16'hFFFF, 8'h7E, 1'b1};

        #1;
        check("reset core_req", core_req, 16'h0);
        check("reset core_addr", core_addr[31:0], 32'h0);
        check("reset evt_ack", evt_ack, 1'b0);
        check("reset counters", {ucast_cnt, bcast_cnt, drop_cnt}, 12'h0);
        #12 rst_n = 1'b1;
        tick();

        exp_u = 0;
        exp_b = 0;
        for (int v = 0; v < 6; v++) begin
            evt_addr = vecs[v].addr;
            evt_req  = 1'b1;
            tick();
            check($sformatf("v%0d core_req", v), core_req, vecs[v].exp_req);
            check($sformatf("v%0d slice0", v), core_addr[7:0], vecs[v].exp_pl);
            check($sformatf("v%0d slice15", v), core_addr[127:120], vecs[v].exp_pl);
            check($sformatf("v%0d early evt_ack", v), evt_ack, 1'b0);
            core_ack = vecs[v].exp_req;
            tick();
            core_ack = '0;
            check($sformatf("v%0d core_req after ack", v), core_req, 16'h0);
            check($sformatf("v%0d evt_ack", v), evt_ack, 1'b1);
            tick();
            evt_req = 1'b0;
            check($sformatf("v%0d evt_ack pulse end", v), evt_ack, 1'b0);
            if (vecs[v].is_bc) exp_b++; else exp_u++;
            tick();
            check($sformatf("v%0d ucast_cnt", v), ucast_cnt, exp_u);
            check($sformatf("v%0d bcast_cnt", v), bcast_cnt, exp_b);
        end

        // Stray ack on core 3 while core 5 is pending.
        evt_addr = {8'h22, 4'd5};
        evt_req  = 1'b1;
        tick();
        core_ack = 16'h0008;
        tick();
        core_ack = '0;
        check("stray core_req", core_req, 16'h0020);
        check("stray evt_ack", evt_ack, 1'b0);
        check("stray slice5", core_addr[47:40], 8'h22);
        core_ack = 16'h0020;
        tick();
        core_ack = '0;
        check("stray final evt_ack", evt_ack, 1'b1);
        tick();
        evt_req = 1'b0;
        tick();
        exp_u++;
        check("stray ucast_cnt", ucast_cnt, exp_u);

        // Broadcast with acks returned from core 15 down to core 0.
        evt_addr = {8'h7F, 4'd0};
        evt_req  = 1'b1;
        tick();
        check("bc all req", core_req, 16'hFFFF);
        check("bc slice3", core_addr[31:24], 8'h7F);
        for (int i = 15; i >= 0; i--) begin
            core_ack = 16'h1 << i;
            tick();
            core_ack = '0;
            m = (16'h1 << i) - 16'h1;
            check($sformatf("bc req after ack%0d", i), core_req, m);
            check($sformatf("bc evt_ack after ack%0d", i), evt_ack, (i == 0));
        end
        tick();
        evt_req = 1'b0;
        tick();
        exp_b++;
        check("bc bcast_cnt", bcast_cnt, exp_b);

        // Reset with four broadcast acks outstanding.
        evt_addr = {8'h55, 4'd1};
        evt_req  = 1'b1;
        tick();
        for (int i = 15; i >= 4; i--) begin
            core_ack = 16'h1 << i;
            tick();
        end
        core_ack = '0;
        check("mid-rst outstanding", core_req, 16'h000F);
        evt_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst core_req", core_req, 16'h0);
        check("rst core_addr lo", core_addr[31:0], 32'h0);
        check("rst core_addr hi", core_addr[127:96], 32'h0);
        check("rst evt_ack", evt_ack, 1'b0);
        check("rst counters", {ucast_cnt, bcast_cnt, drop_cnt}, 12'h0);
        tick();
        tick();
        check("rst no evt_ack", evt_ack, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        evt_addr = {8'h11, 4'd10};
        evt_req  = 1'b1;
        tick();
        check("post-rst core_req", core_req, 16'h0400);
        core_ack = 16'h0400;
        tick();
        core_ack = '0;
        check("post-rst evt_ack", evt_ack, 1'b1);
        tick();
        evt_req = 1'b0;
        tick();
        check("post-rst ucast_cnt", ucast_cnt, 4'd1);
        check("post-rst bcast_cnt", bcast_cnt, 4'd0);

        // Twenty back-to-back unicasts saturate the 4-bit counter.
        pulses_before = ack_pulses;
        for (int n = 0; n < 20; n++) begin
            evt_addr = {8'(n), 4'(n % 16)};
            evt_req  = 1'b1;
            tick();
            core_ack = 16'h1 << (n % 16);
            tick();
            core_ack = '0;
            tick();
        end
        evt_req = 1'b0;
        tick();
        tick();
        check("sat evt_ack pulses", ack_pulses - pulses_before, 20);
        check("sat ucast_cnt", ucast_cnt, 4'd15);
        check("sat bcast_cnt", bcast_cnt, 4'd0);

        // 12-core instance: out-of-range id, boundary ids, broadcast ignoring id.
        r_evt_addr = {8'h12, 4'd13};
        r_evt_req  = 1'b1;
        tick();
        check("drop core_req", r_core_req, 12'h0);
        check("drop evt_ack k+1", r_evt_ack, 1'b1);
        tick();
        r_evt_req = 1'b0;
        check("drop evt_ack end", r_evt_ack, 1'b0);
        tick();
        check("drop_cnt", r_drop_cnt, 16'd1);
        check("drop ucast_cnt", r_ucast_cnt, 16'd0);

        r_evt_addr = {8'h12, 4'd12};
        r_evt_req  = 1'b1;
        tick();
        check("drop12 core_req", r_core_req, 12'h0);
        check("drop12 evt_ack", r_evt_ack, 1'b1);
        tick();
        r_evt_req = 1'b0;
        tick();
        check("drop12 drop_cnt", r_drop_cnt, 16'd2);

        r_evt_addr = {8'h9A, 4'd11};
        r_evt_req  = 1'b1;
        tick();
        check("id11 core_req", r_core_req, 12'h800);
        check("id11 slice11", r_core_addr[95:88], 8'h9A);
        r_core_ack = 12'h800;
        tick();
        r_core_ack = '0;
        check("id11 evt_ack", r_evt_ack, 1'b1);
        tick();
        r_evt_req = 1'b0;
        tick();
        check("id11 ucast_cnt", r_ucast_cnt, 16'd1);

        r_evt_addr = {8'h60, 4'd14};
        r_evt_req  = 1'b1;
        tick();
        check("bc id14 core_req", r_core_req, 12'hFFF);
        r_core_ack = 12'hFFF;
        tick();
        r_core_ack = '0;
        check("bc id14 evt_ack", r_evt_ack, 1'b1);
        tick();
        r_evt_req = 1'b0;
        tick();
        check("bc id14 bcast_cnt", r_bcast_cnt, 16'd1);
        check("bc id14 drop_cnt", r_drop_cnt, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
